// File: rtl/sweep_ctrl.sv
// sweep_ctrl: frequency-sweep sequencer feeding the en/incr inputs of the
// signal-generator address counter. It steps the increment from a start value
// towards a stop value and holds each step for a programmable dwell.
// Handshake: start / busy / done, with abort and an optional looping mode.
// Optional build macro SWEEP_CTRL_DOWN_EN adds cfg_dir for downward sweeps.
module sweep_ctrl #(
  parameter int WIDTH   = 8,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   cfg_start_incr,
  input  logic [WIDTH-1:0]   cfg_stop_incr,
  input  logic [WIDTH-1:0]   cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
`ifdef SWEEP_CTRL_DOWN_EN
  input  logic               cfg_dir,
`endif
  input  logic               cfg_loop,
  output logic               en_out,
  output logic [WIDTH-1:0]   incr_out,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, DWELL, DONE} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     start_q, start_d;
  logic [WIDTH-1:0]     stop_q, stop_d;
  logic [WIDTH-1:0]     step_q, step_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic                 loop_q, loop_d;
  logic                 dir_q;
  logic [WIDTH-1:0]     incr_d;
  logic                 en_d, busy_d, done_d;
  logic [WIDTH:0]       nxt;

  // A programmed dwell of zero still holds each step for one cycle.
  function automatic logic [DWELL_W-1:0] dwell_floor(input logic [DWELL_W-1:0] d);
    return (d == '0) ? DWELL_W'(1) : d;
  endfunction

  // Returns {ok, value}: the next increment, computed one bit wider so the
  // carry/borrow is visible and the value can never wrap past the bound.
  // A zero step never advances, so it finishes (or loops) after one dwell.
  function automatic logic [WIDTH:0] next_step(input logic [WIDTH-1:0] cur,
                                               input logic [WIDTH-1:0] stp,
                                               input logic [WIDTH-1:0] stop,
                                               input logic             down);
    logic [WIDTH:0] ext;
    logic           ok;
    if (down) begin
      ext = {1'b0, cur} - {1'b0, stp};
      ok  = !ext[WIDTH] && (ext[WIDTH-1:0] >= stop);
    end else begin
      ext = {1'b0, cur} + {1'b0, stp};
      ok  = (ext <= {1'b0, stop});
    end
    ok = ok && (stp != '0);
    return {ok, ext[WIDTH-1:0]};
  endfunction

`ifdef SWEEP_CTRL_DOWN_EN
  logic dir_d;
  // Sweep direction is latched together with the rest of the configuration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dir_q <= 1'b0;
    else        dir_q <= dir_d;
  end
  // Direction register captures cfg_dir on an accepted start only.
  always_comb begin
    dir_d = dir_q;
    if (state_q == IDLE && start && !abort) dir_d = cfg_dir;
  end
`else
  assign dir_q = 1'b0;
`endif

  // Next-state, next-output and configuration-latch logic.
  always_comb begin
    state_d = state_q;
    start_d = start_q;
    stop_d  = stop_q;
    step_d  = step_q;
    dwell_d = dwell_q;
    loop_d  = loop_q;
    cnt_d   = cnt_q;
    incr_d  = incr_out;
    en_d    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    nxt     = next_step(incr_out, step_q, stop_q, dir_q);
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          start_d = cfg_start_incr;
          stop_d  = cfg_stop_incr;
          step_d  = cfg_step;
          dwell_d = dwell_floor(cfg_dwell);
          loop_d  = cfg_loop;
          cnt_d   = dwell_floor(cfg_dwell);
          incr_d  = cfg_start_incr;
          state_d = DWELL;
          en_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end
      DWELL: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          en_d   = 1'b1;
          busy_d = 1'b1;
          if (cnt_q > DWELL_W'(1)) begin
            cnt_d = cnt_q - DWELL_W'(1);
          end else if (nxt[WIDTH]) begin
            incr_d = nxt[WIDTH-1:0];
            cnt_d  = dwell_q;
          end else if (loop_q) begin
            incr_d = start_q;
            cnt_d  = dwell_q;
          end else begin
            state_d = DONE;
            en_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, configuration and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      start_q  <= '0;
      stop_q   <= '0;
      step_q   <= '0;
      dwell_q  <= '0;
      loop_q   <= 1'b0;
      cnt_q    <= '0;
      incr_out <= '0;
      en_out   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      stop_q   <= stop_d;
      step_q   <= step_d;
      dwell_q  <= dwell_d;
      loop_q   <= loop_d;
      cnt_q    <= cnt_d;
      incr_out <= incr_d;
      en_out   <= en_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

endmodule

// File: tb/tb_sweep_ctrl.sv
// tb_sweep_ctrl: directed and randomized sweeps checked against a
// sequence-list reference model built from the sweep rules.
module tb_sweep_ctrl;
  localparam int W  = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          cfg_loop = 1'b0;
  logic          cfg_dir = 1'b0;
  logic [W-1:0]  cfg_start_incr = '0;
  logic [W-1:0]  cfg_stop_incr = '0;
  logic [W-1:0]  cfg_step = '0;
  logic [DW-1:0] cfg_dwell = '0;
  logic          en_out, busy, done;
  logic [W-1:0]  incr_out;

  int checks = 0;
  int failures = 0;
  int exp_q[$];

  sweep_ctrl #(.WIDTH(W), .DWELL_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_start_incr(cfg_start_incr), .cfg_stop_incr(cfg_stop_incr),
    .cfg_step(cfg_step), .cfg_dwell(cfg_dwell),
`ifdef SWEEP_CTRL_DOWN_EN
    .cfg_dir(cfg_dir),
`endif
    .cfg_loop(cfg_loop),
    .en_out(en_out), .incr_out(incr_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  // Reference: list of increment values per cycle for one sweep period.
  task automatic build(input int st, input int sp, input int stp, input int dw, input bit dn);
    int v;
    int reps;
    exp_q.delete();
    reps = (dw == 0) ? 1 : dw;
    v = st;
    forever begin
      for (int r = 0; r < reps; r++) exp_q.push_back(v);
      if (stp == 0) break;
      if (!dn) begin
        if (v + stp > sp) break;
        v = v + stp;
      end else begin
        if (v - stp < sp) break;
        v = v - stp;
      end
    end
  endtask

  // Present a configuration, pulse start, then scramble cfg (must be ignored).
  task automatic launch(input int st, input int sp, input int stp, input int dw,
                        input bit lp, input bit dn, input bit hold);
    cfg_start_incr = W'(st);
    cfg_stop_incr  = W'(sp);
    cfg_step       = W'(stp);
    cfg_dwell      = DW'(dw);
    cfg_loop       = lp;
    cfg_dir        = dn;
    start          = 1'b1;
    step_clk();
    if (!hold) start = 1'b0;
    cfg_start_incr = W'($urandom);
    cfg_stop_incr  = W'($urandom);
    cfg_step       = W'($urandom);
    cfg_dwell      = DW'($urandom_range(0, 7));
    cfg_loop       = ~lp;
    cfg_dir        = ~dn;
  endtask

  // Check n cycles of the sweep, wrapping the model list for looping sweeps.
  task automatic check_vals(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      if (k > 0) step_clk();
      chk({tag, "_incr"}, 32'(incr_out), 32'(exp_q[k % exp_q.size()]));
      chk({tag, "_en"}, 32'(en_out), 32'd1);
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_done"}, 32'(done), 32'd0);
    end
  endtask

  task automatic check_tail(input string tag);
    step_clk();
    chk({tag, "_done_pulse"}, 32'(done), 32'd1);
    chk({tag, "_done_en"}, 32'(en_out), 32'd0);
    chk({tag, "_done_busy"}, 32'(busy), 32'd0);
    step_clk();
    chk({tag, "_idle_done"}, 32'(done), 32'd0);
    chk({tag, "_idle_en"}, 32'(en_out), 32'd0);
    chk({tag, "_idle_incr_hold"}, 32'(incr_out), 32'(exp_q[exp_q.size()-1]));
  endtask

  initial begin
    int st, sp, stp, dw;
    bit dn;

    // Reset state
    #12;
    chk("rst_en", 32'(en_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_incr", 32'(incr_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step_clk();
    step_clk();
    chk("idle_en", 32'(en_out), 32'd0);

    // Basic up-sweep
    build(4, 10, 3, 2, 1'b0);
    chk("basic_len", 32'(exp_q.size()), 32'd6);
    launch(4, 10, 3, 2, 1'b0, 1'b0, 1'b0);
    check_vals("basic", exp_q.size());
    check_tail("basic");

    // Overflow guard
    build(250, 255, 4, 1, 1'b0);
    launch(250, 255, 4, 1, 1'b0, 1'b0, 1'b0);
    check_vals("ovf", exp_q.size());
    check_tail("ovf");

    // Dwell 0, step 0, start held high through the sweep
    build(5, 9, 0, 0, 1'b0);
    launch(5, 9, 0, 0, 1'b0, 1'b0, 1'b1);
    check_vals("degen", exp_q.size());
    step_clk();
    chk("degen_done", 32'(done), 32'd1);
    chk("degen_done_en", 32'(en_out), 32'd0);
    start = 1'b0;
    step_clk();
    chk("degen_idle_en", 32'(en_out), 32'd0);
    chk("degen_idle_done", 32'(done), 32'd0);
    step_clk();
    chk("degen_idle_busy", 32'(busy), 32'd0);

    // Start greater than stop: single dwell
    build(20, 3, 2, 3, 1'b0);
    launch(20, 3, 2, 3, 1'b0, 1'b0, 1'b0);
    check_vals("rev", exp_q.size());
    check_tail("rev");

    // Loop mode, then abort mid-step
    build(1, 3, 1, 1, 1'b0);
    launch(1, 3, 1, 1, 1'b1, 1'b0, 1'b0);
    check_vals("loop", 3 * exp_q.size() + 1);
    abort = 1'b1;
    step_clk();
    abort = 1'b0;
    chk("abort_en", 32'(en_out), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    step_clk();
    chk("abort_idle_done", 32'(done), 32'd0);
    chk("abort_idle_en", 32'(en_out), 32'd0);

    // Abort has priority over start in IDLE
    abort = 1'b1;
    launch(7, 9, 1, 1, 1'b0, 1'b0, 1'b0);
    abort = 1'b0;
    chk("abort_start_en", 32'(en_out), 32'd0);
    chk("abort_start_busy", 32'(busy), 32'd0);

    // Async reset mid-dwell, then a fresh sweep
    launch(10, 200, 5, 3, 1'b0, 1'b0, 1'b0);
    step_clk();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_en", 32'(en_out), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_incr", 32'(incr_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    build(30, 40, 5, 2, 1'b0);
    launch(30, 40, 5, 2, 1'b0, 1'b0, 1'b0);
    check_vals("fresh", exp_q.size());
    check_tail("fresh");

`ifdef SWEEP_CTRL_DOWN_EN
    // Downward sweep
    build(9, 2, 3, 1, 1'b1);
    launch(9, 2, 3, 1, 1'b0, 1'b1, 1'b0);
    check_vals("down", exp_q.size());
    check_tail("down");
    build(3, 8, 1, 2, 1'b1);
    launch(3, 8, 1, 2, 1'b0, 1'b1, 1'b0);
    check_vals("down_rev", exp_q.size());
    check_tail("down_rev");
`endif

    // Randomized single-shot sweeps
    for (int it = 0; it < 8; it++) begin
      st  = $urandom_range(0, 255);
      sp  = $urandom_range(0, 255);
      stp = $urandom_range(0, 40);
      dw  = $urandom_range(0, 3);
`ifdef SWEEP_CTRL_DOWN_EN
      dn  = 1'($urandom_range(0, 1));
`else
      dn  = 1'b0;
`endif
      build(st, sp, stp, dw, dn);
      launch(st, sp, stp, dw, 1'b0, dn, 1'b0);
      check_vals("rnd", exp_q.size());
      check_tail("rnd");
    end

    // Randomized looping sweeps ended by abort
    for (int it = 0; it < 3; it++) begin
      st  = $urandom_range(0, 100);
      sp  = st + $urandom_range(0, 30);
      stp = $urandom_range(1, 9);
      dw  = $urandom_range(1, 3);
      build(st, sp, stp, dw, 1'b0);
      launch(st, sp, stp, dw, 1'b1, 1'b0, 1'b0);
      check_vals("rnd_loop", 2 * exp_q.size() + 1);
      abort = 1'b1;
      step_clk();
      abort = 1'b0;
      chk("rnd_loop_abort_en", 32'(en_out), 32'd0);
      chk("rnd_loop_abort_done", 32'(done), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
